cpu_ctrl_param: RTL
===================

// Module: cpu_ctrl_param
// PURPOSE
//  Parametrised multi-cycle control unit for the lab CPU datapath (register file, A/G regs, ALU, bus mux).
//  Latches an instruction on run, decodes ALU / MV / MVI / reserved ops, sequences bus mux, register enables, ALU controls.
//  Pulses done on completion and keeps a retired-instruction count.
//  Sits between the instruction source and the datapath, in place of the fixed 8-register 3-state controller.
// PARAMETERS
//  INST_W    16  instruction width; must be >= 2*REG_AW+SEL_W+5
//  REG_COUNT 8   number of GP registers, power of 2, >= 2; REG_AW = $clog2(REG_COUNT)
//  SEL_W     4   ALU function-select width
//  CNT_W     16  retired-instruction counter width
//  MUX_W = $clog2(REG_COUNT+2) (derived): bus mux code width
// PORTS
//  clk       in   1          rising-edge clock
//  reset_n   in   1          asynchronous, active-low reset
//  run       in   1          start request, level, sampled only in IDLE
//  d_inst    in   INST_W     instruction word, captured when en_inst=1
//  mux_sel   out  MUX_W      bus source: 0..REG_COUNT-1 = Rn, REG_COUNT = G, REG_COUNT+1 = DIN (immediate)
//  en        out  REG_COUNT  one-hot register write enable
//  en_s      out  1          load A register
//  en_c      out  1          load G register
//  sel       out  SEL_W      ALU function
//  mode      out  1          ALU mode
//  en_inst   out  1          instruction capture strobe (= run in IDLE)
//  busy      out  1          high in any state other than IDLE
//  done      out  1          one-cycle completion pulse
//  illegal   out  1          high together with done for a reserved opcode
//  retired   out  CNT_W      count of completed instructions, including illegal ones
// BEHAVIOUR
//  Fields, all relative to the MSB:
//    rx = IR[INST_W-1 -: REG_AW]; ry = next REG_AW bits; op = next 2 bits
//    sel = IR[SEL_W+2:3]; mode = IR[2]
//    Default layout: rx 15:13, ry 12:10, op 9:8, sel 6:3, mode 2; bits 7, 1:0 ignored.
//  op: 00 ALU (rx <= rx op ry), 01 MV (rx <= ry), 10 MVI (rx <= DIN), 11 reserved.
//  Reset (async, reset_n=0): state=IDLE, IR=0, retired=0; all outputs 0 immediately, including en_inst.
//  Reset mid-instruction aborts it: no done pulse, no count increment.
//  Outputs decode from state and IR, except en_inst, which also depends on run.
//  Unlisted outputs are 0 in every state. en is never multi-hot.
//  States:
//  IDLE: en_inst=run; if run, IR<=d_inst and go to EXEC1, else stay in IDLE.
//  EXEC1, by op:
//    ALU: mux_sel=rx, en_s=1 -> EXEC2
//    MV:  mux_sel=ry, en[rx]=1, done=1 -> IDLE
//    MVI: mux_sel=REG_COUNT+1, en[rx]=1, done=1 -> IDLE (immediate is valid on DIN during this cycle)
//    reserved: done=1, illegal=1, no enables -> IDLE
//  EXEC2: mux_sel=ry, sel=IR.sel, mode=IR.mode, en_c=1 -> EXEC3
//  EXEC3: mux_sel=REG_COUNT, en[rx]=1, done=1 -> IDLE
//  Latency, counted from the run-sampling edge to the done cycle:
//    MV, MVI, reserved: done in the 1st cycle after capture. ALU: done in the 3rd cycle after capture.
//  rx==ry is legal: MV is a no-op write; ALU reads Rx twice.
//  run held high: a new instruction is captured in the IDLE cycle after done (minimum 1 idle cycle).
//  run and d_inst are ignored while busy=1; IR stays stable until the next capture.
//  retired increments on the edge that ends each done cycle and wraps modulo 2^CNT_W with no flag.
//  Encoded states without a name go to IDLE with all outputs 0.
// STRUCTURE
//  cpu_pkg: state enum (IDLE, EXEC1, EXEC2, EXEC3); op constants OP_ALU/OP_MV/OP_MVI/OP_RSV; field-offset localparams.
//  Sub-module cpu_inst_decode (combinational): IR -> rx, ry, op, sel, mode, onehot(rx).
//  Top holds the FSM, IR register, retired counter and output decode.
// TESTING
//  1. reset_n=0 while in EXEC2 -> outputs 0 the same cycle; after release, state=IDLE, retired=0, no done.
//  2. MVI R5: d_inst=16'hA200, run pulse -> next cycle mux_sel=9, en=8'h20, done=1; retired=1.
//  3. MV R2<-R6: d_inst=16'h5900 -> one cycle with mux_sel=6, en=8'h04, done=1, illegal=0.
//  4. ALU R1<-R1 op R3, sel=4'hA, mode=1: d_inst=16'h2C54 -> en_s with mux_sel=1; then en_c with mux_sel=3, sel=A, mode=1;
//     then mux_sel=8, en=8'h02, done=1.
//  5. Reserved op 16'h0300 -> done=1, illegal=1, en=0, en_s=en_c=0; retired increments.
//  6. run held high for 4 back-to-back MVs -> done every 2nd cycle; d_inst changes while busy are ignored;
//     CNT_W=2 run wraps retired 3->0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the parametrised lab-CPU control unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        EXEC3 = 2'd3
    } state_t;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MV  = 2'b01;
    localparam logic [1:0] OP_MVI = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam int OP_W     = 2;
    localparam int SEL_LSB  = 3;
    localparam int MODE_BIT = 2;

endpackage

// File: rtl/cpu_inst_decode.sv
// Combinational instruction field extraction; register fields are MSB-aligned.
module cpu_inst_decode
    import cpu_pkg::*;
#(
    parameter int INST_W    = 16,
    parameter int REG_COUNT = 8,
    parameter int SEL_W     = 4,
    localparam int REG_AW   = $clog2(REG_COUNT)
) (
    input  logic [INST_W-1:0]    ir,
    output logic [REG_AW-1:0]    rx,
    output logic [REG_AW-1:0]    ry,
    output logic [OP_W-1:0]      op,
    output logic [SEL_W-1:0]     sel,
    output logic                 mode,
    output logic [REG_COUNT-1:0] rx_onehot
);

    assign rx        = ir[INST_W-1 -: REG_AW];
    assign ry        = ir[INST_W-1-REG_AW -: REG_AW];
    assign op        = ir[INST_W-1-2*REG_AW -: OP_W];
    assign sel       = ir[SEL_LSB+SEL_W-1 : SEL_LSB];
    assign mode      = ir[MODE_BIT];
    assign rx_onehot = REG_COUNT'(1) << rx;

    // Gap bits between op and sel, and below mode, carry no meaning.
    logic unused_ir;
    assign unused_ir = ^ir;

endmodule

// File: rtl/cpu_ctrl_param.sv
// Multi-cycle controller: captures an instruction on run, sequences the datapath, counts retirements.
module cpu_ctrl_param
    import cpu_pkg::*;
#(
    parameter int INST_W    = 16,
    parameter int REG_COUNT = 8,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 16,
    localparam int REG_AW   = $clog2(REG_COUNT),
    localparam int MUX_W    = $clog2(REG_COUNT+2)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [INST_W-1:0]    d_inst,
    output logic [MUX_W-1:0]     mux_sel,
    output logic [REG_COUNT-1:0] en,
    output logic                 en_s,
    output logic                 en_c,
    output logic [SEL_W-1:0]     sel,
    output logic                 mode,
    output logic                 en_inst,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired
);

    state_t               state;
    logic [INST_W-1:0]    ir;
    logic [REG_AW-1:0]    rx;
    logic [REG_AW-1:0]    ry;
    logic [OP_W-1:0]      op;
    logic [SEL_W-1:0]     ir_sel;
    logic                 ir_mode;
    logic [REG_COUNT-1:0] rx_onehot;

    cpu_inst_decode #(
        .INST_W    (INST_W),
        .REG_COUNT (REG_COUNT),
        .SEL_W     (SEL_W)
    ) u_decode (
        .ir        (ir),
        .rx        (rx),
        .ry        (ry),
        .op        (op),
        .sel       (ir_sel),
        .mode      (ir_mode),
        .rx_onehot (rx_onehot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ir      <= '0;
            retired <= '0;
        end else begin
            if (done)
                retired <= retired + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (run) begin
                        ir    <= d_inst;
                        state <= EXEC1;
                    end
                end
                EXEC1:   state <= (op == OP_ALU) ? EXEC2 : IDLE;
                EXEC2:   state <= EXEC3;
                EXEC3:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // en_inst is the only output that looks at run; gating with reset_n keeps it low during reset.
    assign en_inst = (state == IDLE) && run && reset_n;
    assign busy    = (state != IDLE);

    always_comb begin
        mux_sel = '0;
        en      = '0;
        en_s    = 1'b0;
        en_c    = 1'b0;
        sel     = '0;
        mode    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state)
            EXEC1: begin
                case (op)
                    OP_ALU: begin
                        mux_sel = MUX_W'(rx);
                        en_s    = 1'b1;
                    end
                    OP_MV: begin
                        mux_sel = MUX_W'(ry);
                        en      = rx_onehot;
                        done    = 1'b1;
                    end
                    OP_MVI: begin
                        mux_sel = MUX_W'(REG_COUNT + 1);
                        en      = rx_onehot;
                        done    = 1'b1;
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            EXEC2: begin
                mux_sel = MUX_W'(ry);
                sel     = ir_sel;
                mode    = ir_mode;
                en_c    = 1'b1;
            end
            EXEC3: begin
                mux_sel = MUX_W'(REG_COUNT);
                en      = rx_onehot;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
